// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the fetch stage
package fetch_unit_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  localparam logic [31:0] HALT_WORD  = 32'h0000_0000;
  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam logic [31:0] BUBBLE_IR  = 32'h0000_0000;
  localparam logic [31:0] BUBBLE_PC4 = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// rtl/fetch_unit_if_id_reg.sv - IF/ID pipeline latch with load, hold and flush
module if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] next_ir,
  input  logic [31:0] next_pc4,
  output logic [31:0] ir,
  output logic [31:0] pc4,
  output logic        valid
);

  // Flush outranks load so a redirect never lets a stale fetch through.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir    <= BUBBLE_IR;
      pc4   <= BUBBLE_PC4;
      valid <= 1'b0;
    end else if (flush) begin
      ir    <= BUBBLE_IR;
      pc4   <= BUBBLE_PC4;
      valid <= 1'b0;
    end else if (load) begin
      ir    <= next_ir;
      pc4   <= next_pc4;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, run/halt FSM and fetch counter feeding the IF/ID latch
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ir,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic [31:0]      pc,
  output logic [31:0]      if_id_ir,
  output logic [31:0]      if_id_pc4,
  output logic             if_id_valid,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  fetch_state_t state, state_next;
  logic [31:0]  pc_next;
  logic [31:0]  pc_plus4;
  logic         load;
  logic         flush;

  assign pc_plus4 = pc + PC_STEP;
  assign halted   = (state == HALT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    load       = 1'b0;
    flush      = 1'b0;
    if (redirect) begin
      pc_next    = {redirect_pc[31:2], 2'b00};
      flush      = 1'b1;
      state_next = RUN;
    end else begin
      case (state)
        RUN: begin
          if (!stall) begin
            if (ir == HALT_WORD) begin
              state_next = HALT;
              flush      = 1'b1;
            end else begin
              pc_next = pc_plus4;
              load    = 1'b1;
            end
          end
        end
        // IF/ID already holds a bubble from the halt-detect flush.
        HALT: state_next = HALT;
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count <= '0;
    end else if (load && (fetch_count != {CNT_W{1'b1}})) begin
      fetch_count <= fetch_count + 1'b1;
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .flush    (flush),
    .next_ir  (ir),
    .next_pc4 (pc_plus4),
    .ir       (if_id_ir),
    .pc4      (if_id_pc4),
    .valid    (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic [31:0]   ir;
  logic          stall;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic [31:0]   pc;
  logic [31:0]   if_id_ir;
  logic [31:0]   if_id_pc4;
  logic          if_id_valid;
  logic          halted;
  logic [CW-1:0] fetch_count;

  logic [31:0] im [16];
  int total;
  int bad;

  localparam logic [31:0] W0  = 32'h0000_2D88;
  localparam logic [31:0] W1  = 32'h0882_FC65;
  localparam logic [31:0] W2  = 32'h0000_2D88;
  localparam logic [31:0] W15 = 32'h0000_0013;

  fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .ir          (ir),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .if_id_ir    (if_id_ir),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  assign ir = im[pc[5:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] e_ir,
                            input logic [31:0] e_pc4, input logic e_valid);
    check({tag, "_ir"}, if_id_ir, e_ir);
    check({tag, "_pc4"}, if_id_pc4, e_pc4);
    check({tag, "_valid"}, {31'd0, if_id_valid}, {31'd0, e_valid});
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"}, pc, 32'h0);
    check_ifid(tag, 32'h0, 32'h0, 1'b0);
    check({tag, "_halted"}, {31'd0, halted}, 32'h0);
    check({tag, "_count"}, {28'd0, fetch_count}, 32'h0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    for (int i = 0; i < 16; i++) im[i] = 32'h0000_1000 + i;
    im[0] = W0;
    im[1] = W1;
    im[2] = W2;
    im[3] = 32'h0;
    im[15] = W15;
    reset = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;

    #12;
    check_reset_state("reset");
    @(negedge clk);
    reset = 1'b1;

    step();
    check_ifid("fetch0", W0, 32'h4, 1'b1);
    check("fetch0_pc", pc, 32'h4);
    check("fetch0_count", {28'd0, fetch_count}, 32'd1);
    step();
    check_ifid("fetch1", W1, 32'h8, 1'b1);
    check("fetch1_count", {28'd0, fetch_count}, 32'd2);
    step();
    check_ifid("fetch2", W2, 32'hC, 1'b1);
    check("fetch2_pc", pc, 32'hC);
    check("fetch2_count", {28'd0, fetch_count}, 32'd3);

    step();
    check("halt_halted", {31'd0, halted}, 32'h1);
    check_ifid("halt", 32'h0, 32'h0, 1'b0);
    check("halt_pc", pc, 32'hC);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) stall = 1'b1;
      if (i == 6) stall = 1'b0;
      step();
      check("halt_hold_pc", pc, 32'hC);
      check("halt_hold_halted", {31'd0, halted}, 32'h1);
      check("halt_hold_count", {28'd0, fetch_count}, 32'd3);
    end

    redirect = 1'b1;
    redirect_pc = 32'h0000_0007;
    step();
    check("redir_pc", pc, 32'h4);
    check("redir_halted", {31'd0, halted}, 32'h0);
    check("redir_valid", {31'd0, if_id_valid}, 32'h0);
    redirect = 1'b0;
    step();
    check_ifid("redir_fetch", W1, 32'h8, 1'b1);
    check("redir_fetch_pc", pc, 32'h8);
    check("redir_fetch_count", {28'd0, fetch_count}, 32'd4);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", pc, 32'h8);
      check_ifid("stall", W1, 32'h8, 1'b1);
      check("stall_count", {28'd0, fetch_count}, 32'd4);
    end
    stall = 1'b0;
    step();
    check_ifid("unstall", W2, 32'hC, 1'b1);
    check("unstall_count", {28'd0, fetch_count}, 32'd5);

    // zero word under pc while stalled must not halt
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("stallzero_halted", {31'd0, halted}, 32'h0);
      check("stallzero_pc", pc, 32'hC);
      check_ifid("stallzero", W2, 32'hC, 1'b1);
    end
    redirect = 1'b1;
    redirect_pc = 32'h0;
    step();
    check("stallredir_pc", pc, 32'h0);
    check_ifid("stallredir", 32'h0, 32'h0, 1'b0);
    check("stallredir_count", {28'd0, fetch_count}, 32'd5);
    redirect = 1'b0;
    stall = 1'b0;
    step();
    check_ifid("refetch0", W0, 32'h4, 1'b1);
    check("refetch0_count", {28'd0, fetch_count}, 32'd6);

    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    check("top_pc", pc, 32'hFFFF_FFFC);
    check("top_valid", {31'd0, if_id_valid}, 32'h0);
    redirect = 1'b0;
    step();
    check("wrap_pc", pc, 32'h0);
    check_ifid("wrap", W15, 32'h0, 1'b1);
    check("wrap_count", {28'd0, fetch_count}, 32'd7);

    im[3] = 32'h0000_0003;
    for (int i = 0; i < 20; i++) step();
    check("sat_pc", pc, 32'h50);
    check("sat_count", {28'd0, fetch_count}, 32'd15);
    check("sat_valid", {31'd0, if_id_valid}, 32'h1);

    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_reset_state("async_reset");
    @(negedge clk);
    reset = 1'b1;
    step();
    check_ifid("post_reset", W0, 32'h4, 1'b1);
    check("post_reset_count", {28'd0, fetch_count}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
